// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e : request FSM encoding (IDLE / WAIT / DISCARD)
//   fetch_entry_t : one instruction-buffer entry {instruction word, its PC}
//   XLEN, RESET_PC_DEFAULT, DEPTH_DEFAULT : shared widths and defaults
//   word_align()  : clears the byte-offset bits of an address
package fetch_unit_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int              DEPTH_DEFAULT    = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // no request outstanding
        ST_WAIT    = 2'd1,  // request outstanding, data will be kept
        ST_DISCARD = 2'd2   // request outstanding, data will be dropped
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle of the fetch unit: instruction-memory handshake, decoder
// handshake and the redirect request from the execute stage.
//   master : the fetch unit (drives imem_req/addr and the instr outputs)
//   slave  : memory + decoder + branch unit side
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_target
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: small circular instruction buffer.
//   clk, reset  : clock, async active-low reset
//   push_i      : write push_data_i at the tail
//   pop_i       : drop the head entry (caller guarantees non-empty)
//   flush_i     : empty the buffer; wins over push/pop
//   count_o     : current occupancy
//   head_o      : head entry (meaningful only when count_o != 0)
module fetch_fifo import fetch_unit_pkg::*; #(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output fetch_entry_t               head_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] count_q;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= bump(wr_q);
            if (pop_i)  rd_q <= bump(rd_q);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a small prefetch buffer.
//   clk, reset : clock, async active-low reset
//   bus        : fetch_unit_if.master -- imem request/ack, decoder
//                instr/valid/ready, redirect/target
// One memory request may be outstanding. A request is only issued when a
// buffer slot is guaranteed for its data, so the buffer never overflows.
// A redirect flushes the buffer; an outstanding request that cannot be
// withdrawn is finished in DISCARD and its data dropped.
module fetch_unit import fetch_unit_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;   // next address to fetch
    logic [XLEN-1:0] addr_q, addr_d;           // address on the memory bus
    logic [XLEN-1:0] last_instr_q, last_pc_q;  // shown while buffer is empty

    logic            push, pop, valid, slot_free;
    logic [CW-1:0]   count, cnt_after;
    logic [XLEN-1:0] target;
    fetch_entry_t    head, push_entry;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (bus.redirect),
        .count_o     (count),
        .head_o      (head)
    );

    assign valid            = (count != '0);
    assign pop              = valid & bus.instr_ready;
    assign target           = word_align(bus.redirect_target);
    assign push             = (state_q == ST_WAIT) & bus.imem_ack & ~bus.redirect;
    assign push_entry.instr = bus.imem_rdata;
    assign push_entry.pc    = addr_q;
    // Occupancy once this cycle's push/pop have landed; a new request is
    // only issued if that still leaves room for its data.
    assign cnt_after        = count + CW'(push) - CW'(pop);
    assign slot_free        = (cnt_after < CW'(DEPTH));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            fetch_pc_q   <= word_align(RESET_PC);
            addr_q       <= word_align(RESET_PC);
            last_instr_q <= '0;
            last_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            if (valid) begin
                last_instr_q <= head.instr;
                last_pc_q    <= head.pc;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.redirect) begin
                    // buffer is flushed this cycle, so a slot is always free
                    state_d    = ST_WAIT;
                    fetch_pc_d = target;
                    addr_d     = target;
                end else if (slot_free) begin
                    state_d = ST_WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            ST_WAIT: begin
                if (bus.imem_ack) begin
                    if (bus.redirect) begin
                        // request just completed: drop its data, no DISCARD
                        fetch_pc_d = target;
                        addr_d     = target;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        addr_d     = fetch_pc_q + 32'd4;
                        state_d    = slot_free ? ST_WAIT : ST_IDLE;
                    end
                end else if (bus.redirect) begin
                    // keep the old address on the bus until it is acked
                    state_d    = ST_DISCARD;
                    fetch_pc_d = target;
                end
            end
            ST_DISCARD: begin
                if (bus.redirect) fetch_pc_d = target;
                if (bus.imem_ack) begin
                    // buffer was flushed on entry and nothing pushed since
                    state_d = ST_WAIT;
                    addr_d  = bus.redirect ? target : fetch_pc_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.imem_req    = (state_q != ST_IDLE);
        bus.imem_addr   = addr_q;
        bus.instr_valid = valid;
        bus.instr       = valid ? head.instr : last_instr_q;
        bus.instr_pc    = valid ? head.pc    : last_pc_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. Two instances: u_dut with
// RESET_PC=0 and u_wrap with RESET_PC=FFFF_FFF8 for the wrap-around case.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    fetch_unit_if bus();
    fetch_unit_if bus2();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk(clk), .reset(reset), .bus(bus));
    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
        .clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;

    // instruction memory contents: a fixed pattern derived from the address
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.imem_ack = 0;  bus.imem_rdata = '0;  bus.instr_ready = 0;
        bus.redirect = 0;  bus.redirect_target = '0;
        bus2.imem_ack = 0; bus2.imem_rdata = '0; bus2.instr_ready = 0;
        bus2.redirect = 0; bus2.redirect_target = '0;
    endtask

    // leaves reset released just after an edge, FSM still in IDLE
    task automatic do_reset();
        idle_inputs();
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        tick();
        tick();
        n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", bus.imem_req); end
        n_chk++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 00000000", bus.imem_addr); end
        n_chk++; if (bus2.imem_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL rst_addr_wrap: got %h expected fffffff8", bus2.imem_addr); end
        n_chk++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", bus.instr_valid); end
        n_chk++; if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h/%h expected 0/0", bus.instr, bus.instr_pc); end
        reset = 1;
        tick();
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: got %b@%h expected 1@00000000", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        tick();
        bus.instr_ready = 1;
        bus.imem_ack = bus.imem_req; bus.imem_rdata = mem(bus.imem_addr);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL zw_pc%0d: got v=%b pc=%h expected v=1 pc=%h", i, bus.instr_valid, bus.instr_pc, 32'(4 * i)); end
            n_chk++; if (bus.instr !== mem(32'(4 * i))) begin n_fail++; $display("FAIL zw_instr%0d: got %h expected %h", i, bus.instr, mem(32'(4 * i))); end
            n_chk++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL zw_req%0d: got %b expected 1", i, bus.imem_req); end
            bus.imem_ack = (i < 3) ? bus.imem_req : 1'b0;
            bus.imem_rdata = mem(bus.imem_addr);
        end
        tick();
        // buffer drained: outputs hold the last instruction
        n_chk++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid: got %b expected 0", bus.instr_valid); end
        n_chk++; if (bus.instr_pc !== 32'd12 || bus.instr !== mem(32'd12)) begin n_fail++; $display("FAIL hold_instr: got %h/%h expected %h/0000000c", bus.instr, bus.instr_pc, mem(32'd12)); end
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd16) begin n_fail++; $display("FAIL hold_req: got %b@%h expected 1@00000010", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_backpressure();
        int age  = 0;
        int acks = 0;
        do_reset();
        tick();
        for (int c = 0; c < 20; c++) begin
            if (bus.instr_valid) begin
                n_chk++; if (bus.instr_pc !== 32'h0 || bus.instr !== mem(32'h0)) begin n_fail++; $display("FAIL bp_stable%0d: got %h/%h expected %h/00000000", c, bus.instr, bus.instr_pc, mem(32'h0)); end
            end
            if (bus.imem_req) age++;
            bus.imem_ack   = bus.imem_req && (age == 3);
            bus.imem_rdata = mem(bus.imem_addr);
            if (bus.imem_ack) begin age = 0; acks++; end
            tick();
        end
        n_chk++; if (acks !== 2) begin n_fail++; $display("FAIL bp_pushes: got %0d expected 2", acks); end
        n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_off: got %b expected 0", bus.imem_req); end
        n_chk++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", bus.instr_valid); end
        // redirect while idle with a full buffer
        bus.imem_ack = 0;
        bus.redirect = 1; bus.redirect_target = 32'h0000_0083;
        tick();
        bus.redirect = 0;
        n_chk++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL idle_redir_flush: got %b expected 0", bus.instr_valid); end
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h80) begin n_fail++; $display("FAIL idle_redir_req: got %b@%h expected 1@00000080", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_redirect_discard();
        do_reset();
        tick();
        bus.redirect = 1; bus.redirect_target = 32'h0000_0103;
        tick();
        bus.redirect = 0;
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL disc_hold1: got %b@%h expected 1@00000000", bus.imem_req, bus.imem_addr); end
        n_chk++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL disc_valid1: got %b expected 0", bus.instr_valid); end
        tick();
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL disc_hold2: got %b@%h expected 1@00000000", bus.imem_req, bus.imem_addr); end
        bus.imem_ack = 1; bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL disc_newreq: got %b@%h expected 1@00000100", bus.imem_req, bus.imem_addr); end
        n_chk++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL disc_dropped: got %b expected 0", bus.instr_valid); end
        bus.imem_ack = 1; bus.imem_rdata = mem(32'h100); bus.instr_ready = 1;
        tick();
        bus.imem_ack = 0;
        n_chk++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h100 || bus.instr !== mem(32'h100)) begin n_fail++; $display("FAIL disc_target: got v=%b %h/%h expected v=1 %h/00000100", bus.instr_valid, bus.instr, bus.instr_pc, mem(32'h100)); end
    endtask

    task automatic test_redirect_with_ack();
        do_reset();
        tick();
        bus.imem_ack = 1; bus.imem_rdata = 32'hBAD0_BAD0;
        bus.redirect = 1; bus.redirect_target = 32'h40;
        tick();
        bus.redirect = 0;
        n_chk++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rack_dropped: got %b expected 0", bus.instr_valid); end
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin n_fail++; $display("FAIL rack_req: got %b@%h expected 1@00000040", bus.imem_req, bus.imem_addr); end
        bus.imem_ack = 1; bus.imem_rdata = mem(32'h40); bus.instr_ready = 1;
        tick();
        bus.imem_ack = 0;
        n_chk++; if (bus.instr_pc !== 32'h40 || bus.instr !== mem(32'h40)) begin n_fail++; $display("FAIL rack_instr: got %h/%h expected %h/00000040", bus.instr, bus.instr_pc, mem(32'h40)); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
        do_reset();
        tick();
        bus2.instr_ready = 1;
        bus2.imem_ack = bus2.imem_req; bus2.imem_rdata = mem(bus2.imem_addr);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (bus2.instr_valid !== 1'b1 || bus2.instr_pc !== exp_pc[i]) begin n_fail++; $display("FAIL wrap_pc%0d: got v=%b pc=%h expected v=1 pc=%h", i, bus2.instr_valid, bus2.instr_pc, exp_pc[i]); end
            bus2.imem_ack = bus2.imem_req; bus2.imem_rdata = mem(bus2.imem_addr);
        end
        bus2.imem_ack = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick();
        tick();
        reset = 0;
        #1;
        n_chk++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_abandon: got req=%b v=%b expected 0/0", bus.imem_req, bus.instr_valid); end
        tick();
        // late ack of the abandoned request arrives right after release
        reset = 1;
        bus.imem_ack = 1; bus.imem_rdata = 32'hBAD1_BAD1;
        tick();
        bus.imem_ack = 0;
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_fresh_req: got %b@%h expected 1@00000000", bus.imem_req, bus.imem_addr); end
        tick();
        n_chk++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_late_ack: got %b expected 0", bus.instr_valid); end
        bus.imem_ack = 1; bus.imem_rdata = mem(32'h0);
        tick();
        bus.imem_ack = 0;
        n_chk++; if (bus.instr_valid !== 1'b1 || bus.instr !== mem(32'h0)) begin n_fail++; $display("FAIL mid_first: got v=%b %h expected v=1 %h", bus.instr_valid, bus.instr, mem(32'h0)); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_discard();
        test_redirect_with_ack();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, instruction buffer entries (legal: 2..4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  word-aligned read address; bits [1:0] always 0.
REQ-007 imem_ack  input  1  request complete; imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr  output  32  instruction word presented to the decoder.
REQ-010 instr_pc  output  32  address of instr.
REQ-011 instr_valid  output  1  instr/instr_pc valid.
REQ-012 instr_ready  input  1  datapath consumes instr this cycle.
REQ-013 redirect  input  1  taken branch or jump resolved (dobranch | dojump).
REQ-014 redirect_target  input  32  new fetch address.

Function
REQ-015 Memory handshake: imem_req and imem_addr held stable until the cycle imem_ack=1; at most one request outstanding.
REQ-016 FSM states: IDLE (no request), WAIT (request outstanding), DISCARD (outstanding request whose data is dropped).
REQ-017 IDLE->WAIT when free slots (DEPTH - count) > 0 and no redirect; imem_req asserted the same cycle at fetch_pc.
REQ-018 WAIT on imem_ack: push {imem_rdata, imem_addr} into buffer, fetch_pc <= fetch_pc+4; stay in WAIT with new address next cycle if a slot remains after this cycle's push/pop, else IDLE.
REQ-019 Zero-wait memory (ack every cycle) with continuous instr_ready SHALL sustain one instruction per cycle.
REQ-020 Buffer empty: instr_valid=0; instr, instr_pc hold last values.
REQ-021 instr_valid=1 and instr_ready=0: instr and instr_pc stable.
REQ-022 Buffer full: no new request issued; an outstanding request never overflows (issue only when a slot is reserved).
REQ-023 Redirect: buffer flushed (instr_valid=0 next cycle), fetch_pc <= {redirect_target[31:2],2'b00}.
REQ-024 Redirect in WAIT without imem_ack: go to DISCARD; request stays asserted at its old address until ack; ack data dropped; then request at target.
REQ-025 Redirect in same cycle as imem_ack: ack data dropped, next state WAIT at target (no DISCARD).
REQ-026 Redirect while in DISCARD: target overwritten by latest value, remain in DISCARD.
REQ-027 Redirect with instr_ready same cycle: head instruction counts as consumed; remainder flushed.
REQ-028 Redirect in IDLE: request at target issued next cycle.
REQ-029 PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-030 First instruction reaches instr_valid no earlier than one cycle after the accepting imem_ack.

Reset
REQ-031 While reset=0: imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, buffer empty, FSM=IDLE, fetch_pc=RESET_PC.
REQ-032 Reset mid-request: request abandoned immediately; late imem_ack after reset release ignored unless a new request is outstanding.
REQ-033 First imem_req asserted in the first clk edge after reset deassertion.

Structure
REQ-034 Shared package: FSM state encoding, RESET_PC default, DEPTH default, instruction width 32.
REQ-035 Buffer implemented as sub-module fetch_fifo (push, pop, flush, count, head data); FSM and PC logic in fetch_unit.

Verification
REQ-036 Reset release, RESET_PC=0, ack every cycle, ready=1 -> instr_pc 0,4,8,12 on consecutive cycles, imem_req never drops.
REQ-037 ack 3 cycles after each req, ready=0 -> exactly DEPTH pushes, imem_req=0 afterwards, instr/instr_pc at 0 stable.
REQ-038 Redirect to 32'h0000_0103 while WAIT with ack delayed 2 cycles -> old address held, its data dropped, next request addr 32'h0000_0100, instr_valid=0 until that ack.
REQ-039 Redirect and imem_ack same cycle, target 32'h40 -> ack data never appears on instr, next imem_addr 32'h40.
REQ-040 RESET_PC=32'hFFFF_FFF8, zero-wait -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-041 reset=0 asserted during WAIT, ack arrives 1 cycle after release -> ack ignored, instr_valid=0, fresh request at RESET_PC.
